// File: rtl/poly_bank_sched.sv
// Polyphase decimator sequencer: input commutator, tap sweep, pipeline drain and bank summation.
// Optional sticky overrun flag enabled by defining POLY_BANK_SCHED_OVERRUN_EN.
module poly_bank_sched #(
    parameter int M             = 20,
    parameter int M_LOG2        = 5,
    parameter int BANK_LEN      = 60,
    parameter int BANK_LEN_LOG2 = 6,
    parameter int INPUT_WIDTH   = 12,
    parameter int ACC_WIDTH     = 39,
    parameter int DSP_LAT       = 3,
    parameter int OUTPUT_WIDTH  = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     samp_en,
    input  logic [INPUT_WIDTH-1:0]   din,
    output logic [M-1:0]             bank_we,
    output logic [INPUT_WIDTH-1:0]   bank_din,
    output logic [BANK_LEN_LOG2-1:0] tap_addr,
    output logic [BANK_LEN_LOG2-1:0] tap_rd_addr,
    output logic [M_LOG2-1:0]        bank_sel,
    input  logic [ACC_WIDTH-1:0]     bank_dout,
    output logic [OUTPUT_WIDTH-1:0]  dout,
    output logic                     dout_valid,
    output logic                     overrun
);

    // state | meaning
    // IDLE  | waiting for a completed frame
    // SWEEP | driving tap_addr 1..BANK_LEN
    // DRAIN | tap_addr idle, waiting DSP_LAT cycles for bank results
    // SUM   | walking bank_sel 0..M-1 and accumulating bank_dout
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, SUM} state_t;

    localparam int CNT_W = ((BANK_LEN_LOG2 > M_LOG2) ? BANK_LEN_LOG2 : M_LOG2) + 1;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [M_LOG2-1:0]       cidx;
    logic                    start_req;
    logic                    pending, pending_nxt;
    logic [OUTPUT_WIDTH-1:0] acc, acc_nxt, bank_ext;
    logic                    dout_valid_nxt;
    logic                    busy, accept;

    assign busy     = (state == SWEEP) || (state == DRAIN);
    assign accept   = samp_en && !busy;
    assign bank_ext = {{(OUTPUT_WIDTH-ACC_WIDTH){bank_dout[ACC_WIDTH-1]}}, bank_dout};

    // Commutator: a write to bank 0 closes the frame and requests a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            cidx      <= M_LOG2'(M-1);
            bank_we   <= '0;
            bank_din  <= '0;
            start_req <= 1'b0;
        end else begin
            bank_we   <= '0;
            start_req <= 1'b0;
            if (accept) begin
                bank_we   <= M'(1) << cidx;
                bank_din  <= din;
                start_req <= (cidx == '0);
                cidx      <= (cidx == '0) ? M_LOG2'(M-1) : cidx - M_LOG2'(1);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pending_nxt    = pending;
        acc_nxt        = acc;
        dout_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start_req || pending) begin
                    state_nxt   = SWEEP;
                    cnt_nxt     = CNT_W'(1);
                    pending_nxt = 1'b0;
                end
            end
            SWEEP: begin
                if (cnt == CNT_W'(BANK_LEN)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DSP_LAT-1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = SUM;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SUM: begin
                acc_nxt = (cnt == '0) ? bank_ext : acc + bank_ext;
                if (start_req) begin
                    pending_nxt = 1'b1;
                end
                if (cnt == CNT_W'(M-1)) begin
                    dout_valid_nxt = 1'b1;
                    if (start_req || pending) begin
                        state_nxt   = SWEEP;
                        cnt_nxt     = CNT_W'(1);
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // tap_rd_addr is the next tap_addr, so a 1-cycle ROM lines up with tap_addr.
    assign tap_rd_addr = (state_nxt == SWEEP) ? cnt_nxt[BANK_LEN_LOG2-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            acc        <= '0;
            tap_addr   <= '0;
            bank_sel   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            acc        <= acc_nxt;
            tap_addr   <= tap_rd_addr;
            bank_sel   <= (state_nxt == SUM) ? cnt_nxt[M_LOG2-1:0] : '0;
            dout_valid <= dout_valid_nxt;
            if (dout_valid_nxt) begin
                dout <= acc_nxt;
            end
        end
    end

`ifdef POLY_BANK_SCHED_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (samp_en && busy) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule
